// File: rtl/leaf_index_collector.sv
// rtl/leaf_index_collector.sv - gathers one leaf index per tree lane, packs them and queues results in a FIFO
// Optional: LEAF_COLLECTOR_STALL_CNT_EN adds the stallCycles output and counter.
module leaf_index_collector #(
    parameter int NUM_TREES = 3,
    parameter int IDX_W     = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_TREES*IDX_W-1:0]   nodeIdxIn,
    input  logic [NUM_TREES-1:0]         nValIn,
    output logic [NUM_TREES-1:0]         recOut,
    output logic [NUM_TREES*IDX_W-1:0]   resOut,
    output logic                         resVal,
    input  logic                         resRec,
    output logic [CNT_W-1:0]             sampCount,
`ifdef LEAF_COLLECTOR_STALL_CNT_EN
    output logic [CNT_W-1:0]             stallCycles,
`endif
    output logic [$clog2(DEPTH):0]       fifoCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = NUM_TREES * IDX_W;

    typedef enum logic {COLLECT, STALL} state_t;

    state_t               state;
    logic [NUM_TREES-1:0] laneFull;
    logic [WW-1:0]        laneIdx;
    logic [WW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wp;
    logic [AW-1:0]        rp;
    logic                 allFull;
    logic                 fifoFull;
    logic                 push;
    logic                 pop;

    // Push decision uses registered state only, so a pop freeing the last slot
    // lets the held sample in one cycle later rather than bypassing.
    assign allFull  = &laneFull;
    assign fifoFull = (fifoCount == CW'(DEPTH));
    assign push     = allFull && !fifoFull;
    assign pop      = resVal && resRec;

    assign recOut = ~laneFull & {NUM_TREES{~rst}};
    assign resVal = (fifoCount != '0) && !rst;
    assign resOut = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            laneFull  <= '0;
            laneIdx   <= '0;
            wp        <= '0;
            rp        <= '0;
            fifoCount <= '0;
            sampCount <= '0;
            state     <= COLLECT;
        end else begin
            for (int i = 0; i < NUM_TREES; i++) begin
                if (nValIn[i] && recOut[i]) begin
                    laneIdx[i*IDX_W +: IDX_W] <= nodeIdxIn[i*IDX_W +: IDX_W];
                    laneFull[i]               <= 1'b1;
                end
            end

            if (push) begin
                mem[wp]   <= laneIdx;
                wp        <= wp + AW'(1);
                laneFull  <= '0;
                sampCount <= sampCount + CNT_W'(1);
            end

            if (pop) begin
                rp <= rp + AW'(1);
            end

            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase

            case (state)
                COLLECT: if (allFull && fifoFull) state <= STALL;
                STALL:   if (push) state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef LEAF_COLLECTOR_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles <= '0;
        end else if (allFull && fifoFull && (stallCycles != {CNT_W{1'b1}})) begin
            stallCycles <= stallCycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_leaf_index_collector.sv
// tb/tb_leaf_index_collector.sv - directed self-checking bench for leaf_index_collector
module tb_leaf_index_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] nodeIdxIn;
    logic [2:0]  nValIn;
    logic [2:0]  recOut;
    logic [11:0] resOut;
    logic        resVal;
    logic        resRec;
    logic [15:0] sampCount;
    logic [2:0]  fifoCount;
`ifdef LEAF_COLLECTOR_STALL_CNT_EN
    logic [15:0] stallCycles;
`endif

    int vectors = 0;
    int errors  = 0;

    leaf_index_collector dut (
        .clk        (clk),
        .rst        (rst),
        .nodeIdxIn  (nodeIdxIn),
        .nValIn     (nValIn),
        .recOut     (recOut),
        .resOut     (resOut),
        .resVal     (resVal),
        .resRec     (resRec),
        .sampCount  (sampCount),
`ifdef LEAF_COLLECTOR_STALL_CNT_EN
        .stallCycles(stallCycles),
`endif
        .fifoCount  (fifoCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture edge followed by the edge on which the push would happen.
    task automatic send(input logic [11:0] word);
        nodeIdxIn = word;
        nValIn    = 3'b111;
        tick();
        nValIn    = 3'b000;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; nValIn = 3'b000; nodeIdxIn = '0; resRec = 1'b0;
        tick(); tick();
        vectors++; if (recOut !== 3'b000) begin errors++; $display("FAIL reset_recout got %b exp 000", recOut); end
        vectors++; if (resVal !== 1'b0) begin errors++; $display("FAIL reset_resval got %b exp 0", resVal); end
        vectors++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL reset_fifocount got %0d exp 0", fifoCount); end
        vectors++; if (sampCount !== 16'd0) begin errors++; $display("FAIL reset_sampcount got %0d exp 0", sampCount); end
        rst = 1'b0;
        #1;
        vectors++; if (recOut !== 3'b111) begin errors++; $display("FAIL reset_release_recout got %b exp 111", recOut); end
    endtask

    task automatic test_aligned();
        resRec = 1'b1;
        nodeIdxIn = {4'd9, 4'd5, 4'd2};
        nValIn = 3'b111;
        tick();
        nValIn = 3'b000;
        vectors++; if (recOut !== 3'b000) begin errors++; $display("FAIL aligned_recout_low got %b exp 000", recOut); end
        vectors++; if (resVal !== 1'b0) begin errors++; $display("FAIL aligned_resval_early got %b exp 0", resVal); end
        tick();
        vectors++; if (resVal !== 1'b1) begin errors++; $display("FAIL aligned_resval got %b exp 1", resVal); end
        vectors++; if (resOut !== 12'h952) begin errors++; $display("FAIL aligned_resout got %h exp 952", resOut); end
        vectors++; if (sampCount !== 16'd1) begin errors++; $display("FAIL aligned_sampcount got %0d exp 1", sampCount); end
        vectors++; if (recOut !== 3'b111) begin errors++; $display("FAIL aligned_recout_ready got %b exp 111", recOut); end
        tick();
        vectors++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL aligned_drained got %0d exp 0", fifoCount); end
    endtask

    task automatic test_skewed();
        resRec = 1'b0;
        nodeIdxIn = {4'd0, 4'd0, 4'd7};
        nValIn = 3'b001;
        tick();
        vectors++; if (recOut !== 3'b110) begin errors++; $display("FAIL skew_lane0 got %b exp 110", recOut); end
        // Extra valid on a full lane must be ignored.
        nodeIdxIn = {4'd0, 4'd0, 4'hF};
        tick(); tick();
        nodeIdxIn = {4'd3, 4'd0, 4'hF};
        nValIn = 3'b101;
        tick();
        vectors++; if (recOut !== 3'b010) begin errors++; $display("FAIL skew_lane2 got %b exp 010", recOut); end
        nValIn = 3'b000;
        tick();
        nodeIdxIn = {4'd0, 4'd1, 4'd0};
        nValIn = 3'b010;
        tick();
        nValIn = 3'b000;
        vectors++; if (recOut !== 3'b000) begin errors++; $display("FAIL skew_lane1 got %b exp 000", recOut); end
        vectors++; if (resVal !== 1'b0) begin errors++; $display("FAIL skew_resval_early got %b exp 0", resVal); end
        tick();
        vectors++; if (resOut !== 12'h317 || resVal !== 1'b1) begin errors++; $display("FAIL skew_resout got %h/%b exp 317/1", resOut, resVal); end
        vectors++; if (recOut !== 3'b111) begin errors++; $display("FAIL skew_ready_again got %b exp 111", recOut); end
        resRec = 1'b1;
        tick();
        resRec = 1'b0;
        vectors++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL skew_drained got %0d exp 0", fifoCount); end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_q [5];
        do_reset();
        resRec = 1'b0;
        exp_q[0] = 12'h123; exp_q[1] = 12'h456; exp_q[2] = 12'h789;
        exp_q[3] = 12'hABC; exp_q[4] = 12'hDEF;
        for (int k = 0; k < 5; k++) send(exp_q[k]);
        tick(); tick();
        vectors++; if (fifoCount !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d exp 4", fifoCount); end
        vectors++; if (recOut !== 3'b000) begin errors++; $display("FAIL bp_stall_recout got %b exp 000", recOut); end
        vectors++; if (sampCount !== 16'd4) begin errors++; $display("FAIL bp_stall_sampcount got %0d exp 4", sampCount); end
        vectors++; if (resOut !== exp_q[0]) begin errors++; $display("FAIL bp_head_stable got %h exp %h", resOut, exp_q[0]); end
        resRec = 1'b1;
        tick();
        vectors++; if (fifoCount !== 3'd3 || sampCount !== 16'd4) begin errors++; $display("FAIL bp_pop_only got %0d/%0d exp 3/4", fifoCount, sampCount); end
        vectors++; if (resOut !== exp_q[1]) begin errors++; $display("FAIL bp_order1 got %h exp %h", resOut, exp_q[1]); end
        tick();
        vectors++; if (fifoCount !== 3'd3 || sampCount !== 16'd5) begin errors++; $display("FAIL bp_late_push got %0d/%0d exp 3/5", fifoCount, sampCount); end
        vectors++; if (recOut !== 3'b111) begin errors++; $display("FAIL bp_lanes_free got %b exp 111", recOut); end
        for (int k = 2; k < 5; k++) begin
            vectors++; if (resOut !== exp_q[k] || resVal !== 1'b1) begin errors++; $display("FAIL bp_order%0d got %h exp %h", k, resOut, exp_q[k]); end
            tick();
        end
        vectors++; if (resVal !== 1'b0 || fifoCount !== 3'd0) begin errors++; $display("FAIL bp_empty got %b/%0d exp 0/0", resVal, fifoCount); end
    endtask

    task automatic test_push_pop();
        do_reset();
        resRec = 1'b0;
        send(12'h111);
        send(12'h222);
        vectors++; if (fifoCount !== 3'd2) begin errors++; $display("FAIL pp_pre_count got %0d exp 2", fifoCount); end
        nodeIdxIn = 12'h333;
        nValIn = 3'b111;
        tick();
        nValIn = 3'b000;
        resRec = 1'b1;
        tick();
        vectors++; if (fifoCount !== 3'd2) begin errors++; $display("FAIL pp_count got %0d exp 2", fifoCount); end
        vectors++; if (resOut !== 12'h222) begin errors++; $display("FAIL pp_head got %h exp 222", resOut); end
        tick();
        vectors++; if (resOut !== 12'h333 || fifoCount !== 3'd1) begin errors++; $display("FAIL pp_tail got %h/%0d exp 333/1", resOut, fifoCount); end
        tick();
        resRec = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        resRec = 1'b0;
        send(12'h0A1);
        send(12'h0A2);
        send(12'h0A3);
        nodeIdxIn = 12'h00E;
        nValIn = 3'b001;
        tick();
        nValIn = 3'b000;
        rst = 1'b1;
        #1;
        vectors++; if (recOut !== 3'b000 || resVal !== 1'b0) begin errors++; $display("FAIL rm_during got %b/%b exp 000/0", recOut, resVal); end
        tick();
        vectors++; if (fifoCount !== 3'd0 || sampCount !== 16'd0) begin errors++; $display("FAIL rm_cleared got %0d/%0d exp 0/0", fifoCount, sampCount); end
        rst = 1'b0;
        #1;
        vectors++; if (recOut !== 3'b111 || resVal !== 1'b0) begin errors++; $display("FAIL rm_release got %b/%b exp 111/0", recOut, resVal); end
        nodeIdxIn = 12'h560;
        nValIn = 3'b110;
        tick();
        nValIn = 3'b000;
        tick();
        vectors++; if (resVal !== 1'b0) begin errors++; $display("FAIL rm_stale_lane0 got %b exp 0", resVal); end
        nodeIdxIn = 12'h001;
        nValIn = 3'b001;
        tick();
        nValIn = 3'b000;
        tick();
        vectors++; if (resOut !== 12'h561 || resVal !== 1'b1) begin errors++; $display("FAIL rm_fresh got %h/%b exp 561/1", resOut, resVal); end
    endtask

`ifdef LEAF_COLLECTOR_STALL_CNT_EN
    task automatic test_stall_count();
        do_reset();
        resRec = 1'b0;
        for (int k = 0; k < 5; k++) send(12'h100 + 12'(k));
        vectors++; if (stallCycles !== 16'd1) begin errors++; $display("FAIL stall_first got %0d exp 1", stallCycles); end
        repeat (9) tick();
        vectors++; if (stallCycles !== 16'd10) begin errors++; $display("FAIL stall_ten got %0d exp 10", stallCycles); end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_aligned();
        test_skewed();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
`ifdef LEAF_COLLECTOR_STALL_CNT_EN
        test_stall_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
